// File: rtl/alu_seq_if.sv
// Handshake bundle between the operand sequencer, alu_seq and the result consumer.
// The master modport is the sequencer/consumer side; slave is the ALU itself.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, carry, zero, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, carry, zero, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add multiplier, with a registered, back-pressurable result stage.
module alu_seq #(
  parameter int unsigned WIDTH  = 20,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  localparam int unsigned     CW    = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0]  W_LIM = (WIDTH + 1)'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_XOR = 3'b001,
    OP_OR  = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  op_t                  op_c;
  logic                 in_ready;
  logic                 accept;
  logic                 start_mul;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_carry;
  logic [WIDTH:0]       wide;
  logic [2*WIDTH-1:0]   sh_ext;
  logic                 shift_big;
  logic [WIDTH:0]       step_sum;
  logic [2*WIDTH-1:0]   step_prod;

  assign op_c      = op_t'(bus.op);
  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
  assign accept    = bus.in_valid && in_ready;
  assign start_mul = MUL_EN && (op_c == OP_MUL);

  // Single-cycle datapath. Shifts run through a double-width vector so the
  // last bit shifted out lands at a fixed position next to the result.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    wide      = '0;
    sh_ext    = '0;
    shift_big = ({1'b0, bus.b} >= W_LIM);
    case (op_c)
      OP_AND: alu_res = bus.a & bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_ADD: begin
        wide      = {1'b0, bus.a} + {1'b0, bus.b};
        alu_res   = wide[WIDTH-1:0];
        alu_carry = wide[WIDTH];
      end
      OP_SUB: begin
        wide      = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res   = wide[WIDTH-1:0];
        alu_carry = wide[WIDTH];
      end
      OP_SHL: begin
        if (!shift_big) begin
          sh_ext    = {{WIDTH{1'b0}}, bus.a} << bus.b;
          alu_res   = sh_ext[WIDTH-1:0];
          alu_carry = sh_ext[WIDTH];
        end
      end
      OP_SHR: begin
        if (!shift_big) begin
          sh_ext    = {bus.a, {WIDTH{1'b0}}} >> bus.b;
          alu_res   = sh_ext[2*WIDTH-1:WIDTH];
          alu_carry = sh_ext[WIDTH-1];
        end
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // Right-shifting product register: upper half accumulates, lower half holds
  // the remaining multiplier bits; after WIDTH steps it holds the full product.
  always_comb begin
    step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    step_prod = {step_sum, prod_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && bus.out_ready && !bus.in_valid) begin
          state_d = IDLE;
        end
        if (accept) begin
          if (start_mul) begin
            state_d = EXEC;
            mcand_d = bus.a;
            prod_d  = {{WIDTH{1'b0}}, bus.b};
            cnt_d   = '0;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            carry_d  = alu_carry;
            zero_d   = (alu_res == '0);
          end
        end
      end
      EXEC: begin
        prod_d = step_prod;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = step_prod[WIDTH-1:0];
          carry_d  = |step_prod[2*WIDTH-1:WIDTH];
          zero_d   = (step_prod[WIDTH-1:0] == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == EXEC);
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=20, MUL_EN=1): directed vector table, hand-written
// handshake/reset sequences, then random traffic against an arithmetic model.
module tb_alu_seq;

  localparam int W = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {carry, result} from plain unsigned arithmetic.
  function automatic logic [W:0] model(input logic [2:0] op, input longint unsigned a,
                                       input longint unsigned b);
    longint unsigned mask;
    longint unsigned r;
    logic            c;
    mask = (64'd1 << W) - 1;
    r    = 0;
    c    = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a ^ b;
      3'd2: r = a | b;
      3'd3: begin r = a + b; c = (r > mask); end
      3'd4: begin c = (a < b); r = a - b; end
      3'd5: if (b < W) begin
              r = a << b;
              c = (b == 0) ? 1'b0 : 1'(a >> (W - b));
            end
      3'd6: if (b < W) begin
              r = a >> b;
              c = (b == 0) ? 1'b0 : 1'(a >> (b - 1));
            end
      default: begin r = a * b; c = ((r >> W) != 0); end
    endcase
    r = r & mask;
    return {c, r[W-1:0]};
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic c, output logic z,
                        output int lat, output int bcnt, output int rdy_busy);
    int guard;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("accept_timeout", 64'(guard >= 100), 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.op       = 3'($urandom);
    lat      = 1;
    bcnt     = 0;
    rdy_busy = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy) bcnt++;
      if (bus.busy && bus.in_ready) rdy_busy++;
      @(posedge clk); #1;
      lat++;
    end
    r = bus.result;
    c = bus.carry;
    z = bus.zero;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] r;
    logic         c, z;
    int           lat, bcnt, rdy_busy;
    logic [W:0]   exp_q[$];
    logic [W:0]   sexp[8];
    logic [W:0]   e;
    int           stale;
    int           guard;

    vt.push_back('{3'd3, 20'hFFFFF, 20'h00001, 20'h00000, 1'b1, 1'b1, 1});
    vt.push_back('{3'd4, 20'h00003, 20'h00005, 20'hFFFFE, 1'b1, 1'b0, 1});
    vt.push_back('{3'd5, 20'h80001, 20'h00001, 20'h00002, 1'b1, 1'b0, 1});
    vt.push_back('{3'd5, 20'hFFFFF, 20'h00014, 20'h00000, 1'b0, 1'b1, 1});
    vt.push_back('{3'd7, 20'h00123, 20'h00045, 20'h04E6F, 1'b0, 1'b0, 21});
    vt.push_back('{3'd7, 20'h80000, 20'h00002, 20'h00000, 1'b1, 1'b1, 21});
    vt.push_back('{3'd0, 20'hF0F0F, 20'h0FF00, 20'h00F00, 1'b0, 1'b0, 1});
    vt.push_back('{3'd1, 20'hAAAAA, 20'hAAAAA, 20'h00000, 1'b0, 1'b1, 1});
    vt.push_back('{3'd2, 20'h12340, 20'h00005, 20'h12345, 1'b0, 1'b0, 1});
    vt.push_back('{3'd6, 20'h00003, 20'h00001, 20'h00001, 1'b1, 1'b0, 1});
    vt.push_back('{3'd6, 20'h80000, 20'h00013, 20'h00001, 1'b0, 1'b0, 1});
    vt.push_back('{3'd5, 20'h12345, 20'h00000, 20'h12345, 1'b0, 1'b0, 1});
    vt.push_back('{3'd6, 20'h12345, 20'hFFFFF, 20'h00000, 1'b0, 1'b1, 1});
    vt.push_back('{3'd3, 20'h7FFFF, 20'h80001, 20'h00000, 1'b1, 1'b1, 1});
    vt.push_back('{3'd7, 20'hFFFFF, 20'hFFFFF, 20'h00001, 1'b1, 1'b0, 21});
    vt.push_back('{3'd4, 20'h00005, 20'h00005, 20'h00000, 1'b0, 1'b1, 1});
    vt.push_back('{3'd7, 20'h00000, 20'h12345, 20'h00000, 1'b0, 1'b1, 21});

    // Reset state
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    #1;
    chk("rst.in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.result", 64'(bus.result), 64'd0);
    chk("rst.carry", 64'(bus.carry), 64'd0);
    chk("rst.zero", 64'(bus.zero), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("idle.in_ready", 64'(bus.in_ready), 64'd1);

    // Directed vector table
    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, r, c, z, lat, bcnt, rdy_busy);
      chk($sformatf("vec%0d.result", i), 64'(r), 64'(vt[i].res));
      chk($sformatf("vec%0d.carry", i), 64'(c), 64'(vt[i].c));
      chk($sformatf("vec%0d.zero", i), 64'(z), 64'(vt[i].z));
      chk($sformatf("vec%0d.latency", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("vec%0d.busy_cycles", i), 64'(bcnt), 64'(vt[i].lat - 1));
      chk($sformatf("vec%0d.ready_while_busy", i), 64'(rdy_busy), 64'd0);
    end

    // Back-pressure: OR result held 5 cycles while an XOR waits, then same-cycle accept
    bus.out_ready = 1'b0;
    bus.op = 3'd2; bus.a = 20'h12340; bus.b = 20'h00005; bus.in_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    bus.op = 3'd1; bus.a = 20'h0F0F0; bus.b = 20'hFFFFF;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d.out_valid", k), 64'(bus.out_valid), 64'd1);
      chk($sformatf("bp%0d.result", k), 64'(bus.result), 64'h12345);
      chk($sformatf("bp%0d.carry_zero", k), 64'({bus.carry, bus.zero}), 64'd0);
      chk($sformatf("bp%0d.in_ready", k), 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.in_ready_release", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp.next_valid", 64'(bus.out_valid), 64'd1);
    chk("bp.next_result", 64'(bus.result), 64'hF0F0F);
    @(posedge clk); #1;

    // Streaming: 8 back-to-back AND/OR ops
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        chk($sformatf("stream%0d.out_valid", i - 1), 64'(bus.out_valid), 64'd1);
        chk($sformatf("stream%0d.result", i - 1), 64'(bus.result), 64'(sexp[i-1][W-1:0]));
      end
      if (i < 8) begin
        bus.op       = (i % 2 == 0) ? 3'd0 : 3'd2;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.in_valid = 1'b1;
        sexp[i]      = model(bus.op, 64'(bus.a), 64'(bus.b));
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end

    // Reset in EXEC cycle 7 of a MUL
    bus.op = 3'd7; bus.a = 20'h00123; bus.b = 20'h00045; bus.in_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("mrst.busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mrst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst.busy", 64'(bus.busy), 64'd0);
    chk("mrst.in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mrst.in_ready_after", 64'(bus.in_ready), 64'd1);
    stale = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) stale++;
    end
    chk("mrst.no_stale", 64'(stale), 64'd0);

    // Random traffic against the model, with random back-pressure
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("rand.unexpected_output", 64'd1, 64'd0);
        end else begin
          e = exp_q[0];
          chk("rand.result", 64'(bus.result), 64'(e[W-1:0]));
          chk("rand.carry", 64'(bus.carry), 64'(e[W]));
          chk("rand.zero", 64'(bus.zero), 64'(e[W-1:0] == '0));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      bus.in_valid = ($urandom_range(0, 9) < 6);
      bus.op       = 3'($urandom_range(0, 7));
      bus.a        = W'($urandom);
      bus.b        = (bus.op == 3'd5 || bus.op == 3'd6) ? W'($urandom_range(0, 22)) : W'($urandom);
      #1;
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.op, 64'(bus.a), 64'(bus.b)));
      @(posedge clk); #1;
    end

    // Drain
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || bus.out_valid || bus.busy) && guard < 200) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("drain.unexpected_output", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("drain.result", 64'(bus.result), 64'(e[W-1:0]));
          chk("drain.carry", 64'(bus.carry), 64'(e[W]));
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    chk("drain.remaining", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
